// File: rtl/adder_share_arbiter.sv
// ============================================================================
// adder_share_arbiter: round-robin share of one adder/pass-through unit.
// Optional macro ADDER_ARB_PERF_EN adds a saturating conflict counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3,
  parameter int TAGW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ-1:0]       pass_b,
  input  logic                  flush,
  input  logic                  res_ready,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      result,
  output logic [TAGW-1:0]       res_tag
`ifdef ADDER_ARB_PERF_EN
  ,
  output logic [15:0]           conflict_cnt
`endif
);

  localparam int              PTRW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTRW:0]   NREQ_W = (PTRW+1)'(NREQ);
  localparam logic [PTRW-1:0] LAST   = PTRW'(NREQ - 1);

  logic [PTRW-1:0]  rr_ptr;
  logic [PTRW-1:0]  win;
  logic [PTRW:0]    scan;
  logic             found;
  logic             stall;
  logic             can_issue;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] nxt_result;

  // Scan rr_ptr, rr_ptr+1, ... wrapping modulo NREQ; first asserted req wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (PTRW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!found && req[scan[PTRW-1:0]]) begin
        found = 1'b1;
        win   = scan[PTRW-1:0];
      end
    end
  end

  assign stall     = res_valid & ~res_ready;
  assign can_issue = rst_n & ~stall & ~flush;
  assign grant     = can_issue & found;

  always_comb begin
    gnt = '0;
    if (grant) gnt[win] = 1'b1;
  end

  assign a_sel      = op_a[win*WIDTH +: WIDTH];
  assign b_sel      = op_b[win*WIDTH +: WIDTH];
  assign nxt_result = pass_b[win] ? b_sel : (a_sel + b_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      result    <= '0;
      res_tag   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (grant) begin
      res_valid <= 1'b1;
      result    <= nxt_result;
      res_tag   <= TAGW'(win);
      rr_ptr    <= (win == LAST) ? '0 : win + 1'b1;
    end else if (!stall) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ADDER_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (((req & ~gnt) != '0) && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// ============================================================================
// tb_adder_share_arbiter: directed self-checking bench for adder_share_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adder_share_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 3;
  localparam int TAGW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       pass_b;
  logic                  flush;
  logic                  res_ready;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic [WIDTH-1:0]      result;
  logic [TAGW-1:0]       res_tag;
`ifdef ADDER_ARB_PERF_EN
  logic [15:0]           conflict_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .op_a         (op_a),
    .op_b         (op_b),
    .pass_b       (pass_b),
    .flush        (flush),
    .res_ready    (res_ready),
    .gnt          (gnt),
    .res_valid    (res_valid),
    .result       (result),
    .res_tag      (res_tag)
`ifdef ADDER_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_a[i*WIDTH +: WIDTH] = a;
    op_b[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 3'b111;
    op_a      = '0;
    op_b      = '0;
    pass_b    = '0;
    flush     = 1'b0;
    res_ready = 1'b1;
    #2;
    chk("reset_valid", 64'(res_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_tag", 64'(res_tag), 64'd0);
    chk("reset_gnt", 64'(gnt), 64'd0);
    #1 rst_n = 1'b1;

    // Contention from reset: requesters served 0,1,2,0
    set_op(0, 32'h0000_0100, 32'h0000_0001);
    set_op(1, 32'h0000_2000, 32'h0000_0020);
    set_op(2, 32'h0003_0000, 32'h0000_0300);
    #1 chk("cont_gnt0", 64'(gnt), 64'b001);
    tick();
    chk("cont_tag0", 64'(res_tag), 64'd0);
    chk("cont_res0", 64'(result), 64'h101);
    chk("cont_gnt1", 64'(gnt), 64'b010);
    tick();
    chk("cont_tag1", 64'(res_tag), 64'd1);
    chk("cont_res1", 64'(result), 64'h2020);
    chk("cont_gnt2", 64'(gnt), 64'b100);
    tick();
    chk("cont_tag2", 64'(res_tag), 64'd2);
    chk("cont_res2", 64'(result), 64'h30300);
    chk("cont_gnt3", 64'(gnt), 64'b001);
    tick();
    chk("cont_tag3", 64'(res_tag), 64'd0);
    chk("cont_valid3", 64'(res_valid), 64'd1);

    // lui: pass op_b through, op_a ignored
    req    = 3'b001;
    pass_b = 3'b001;
    set_op(0, 32'hDEAD_BEEF, 32'h1234_5000);
    #1 chk("lui_gnt", 64'(gnt), 64'b001);
    tick();
    chk("lui_valid", 64'(res_valid), 64'd1);
    chk("lui_result", 64'(result), 64'h1234_5000);
    chk("lui_tag", 64'(res_tag), 64'd0);

    // auipc and carry wrap
    pass_b = 3'b000;
    set_op(0, 32'h0000_0100, 32'h0000_1000);
    #1 chk("auipc_gnt", 64'(gnt), 64'b001);
    tick();
    chk("auipc_result", 64'(result), 64'h1100);
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    tick();
    chk("wrap_result", 64'(result), 64'h0);
    chk("wrap_valid", 64'(res_valid), 64'd1);

    // Idle cycle drops valid
    req = 3'b000;
    #1 chk("idle_gnt", 64'(gnt), 64'b000);
    tick();
    chk("idle_valid", 64'(res_valid), 64'd0);

    // Backpressure: hold result while requester 1 waits
    req = 3'b010;
    set_op(1, 32'h0000_1000, 32'h0000_1000);
    #1 chk("bp_first_gnt", 64'(gnt), 64'b010);
    tick();
    chk("bp_first_res", 64'(result), 64'h2000);
    res_ready = 1'b0;
    set_op(1, 32'h0000_0005, 32'h0000_0006);
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_stall_gnt", 64'(gnt), 64'b000);
      tick();
      chk("bp_stall_res", 64'(result), 64'h2000);
      chk("bp_stall_tag", 64'(res_tag), 64'd1);
      chk("bp_stall_valid", 64'(res_valid), 64'd1);
    end
    res_ready = 1'b1;
    #1 chk("bp_release_gnt", 64'(gnt), 64'b010);
    tick();
    chk("bp_release_res", 64'(result), 64'hB);

    // Flush: no grant, pointer stays at 2
    req   = 3'b100;
    flush = 1'b1;
    set_op(2, 32'h0000_0007, 32'h0000_0008);
    #1 chk("flush_gnt", 64'(gnt), 64'b000);
    tick();
    chk("flush_valid", 64'(res_valid), 64'd0);
    flush = 1'b0;
    req   = 3'b111;
    #1 chk("post_flush_gnt", 64'(gnt), 64'b100);
    tick();
    chk("post_flush_res", 64'(result), 64'hF);
    chk("post_flush_tag", 64'(res_tag), 64'd2);
    // Flush beats a simultaneous handshake
    req   = 3'b000;
    flush = 1'b1;
    tick();
    chk("flush_drop_valid", 64'(res_valid), 64'd0);
    flush = 1'b0;

    // Reset mid-stream
    req = 3'b010;
    set_op(1, 32'h0000_0040, 32'h0000_0002);
    tick();
    chk("pre_rst_res", 64'(result), 64'h42);
    req   = 3'b110;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(res_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
`ifdef ADDER_ARB_PERF_EN
    chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    #1 chk("postrst_gnt", 64'(gnt), 64'b010);
    tick();
    chk("postrst_tag", 64'(res_tag), 64'd1);
`ifdef ADDER_ARB_PERF_EN
    chk("postrst_cnt", 64'(conflict_cnt), 64'd1);
`endif
    req = 3'b000;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit adder/pass-through unit between NREQ execute-stage requesters.
- Requester roles are fixed by index:
  - 0 = U-type (lui/auipc) result.
  - 1 = branch/jal target.
  - 2 = load/store address.
- Arbitration is round-robin with a one-hot grant.
- Result is registered, tagged with the winning index, and held under downstream backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NREQ, 3, number of requesters (2..8).
- TAGW, 2, width of result tag; must satisfy 2^TAGW >= NREQ.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; held until matching gnt bit seen.
- op_a  input  NREQ*WIDTH  operand A per requester, slice i = [i*WIDTH +: WIDTH] (pc for auipc/branch, rs1 for mem).
- op_b  input  NREQ*WIDTH  operand B per requester, same slicing (already-extended immediate).
- pass_b  input  NREQ  per requester: 1 = result is op_b unchanged (lui), 0 = op_a+op_b.
- flush  input  1  synchronous pipeline flush.
- res_ready  input  1  downstream accepts result this cycle.
- gnt  output  NREQ  one-hot grant, combinational, same cycle as winning req.
- res_valid  output  1  registered result valid.
- result  output  WIDTH  registered result.
- res_tag  output  TAGW  index of requester that produced result.

Behaviour:
- Reset (rst_n=0, immediate, independent of clk):
  - res_valid=0, result=0, res_tag=0.
  - Round-robin pointer rr_ptr=0.
  - gnt=0 while in reset.
  - Any result in flight is discarded.
- Definitions:
  - stall = res_valid & ~res_ready.
  - can_issue = ~stall & ~flush.
- Grant:
  - When can_issue and req!=0, exactly one gnt bit is set.
  - Winner = first asserted req index scanning rr_ptr, rr_ptr+1, ... wrapping mod NREQ.
  - Otherwise gnt=0.
- On each rising clk edge when a grant is issued:
  - result <= pass_b[w] ? op_b[w] : (op_a[w]+op_b[w]) mod 2^WIDTH; carry dropped, no overflow flag.
  - res_tag <= w; res_valid <= 1.
  - rr_ptr <= (w+1) mod NREQ.
- Latency:
  - Request to gnt: 0 cycles.
  - gnt to res_valid: 1 cycle.
  - Throughput: 1 op/cycle when res_ready=1.
- No grant, no stall, no flush: res_valid <= 0, rr_ptr unchanged, result/res_tag hold previous values.
- Stall:
  - result, res_tag and res_valid are held; gnt=0; rr_ptr unchanged.
  - A requester keeps req and operands stable until granted.
- Flush:
  - res_valid <= 0 and gnt=0 that cycle, regardless of stall.
  - rr_ptr unchanged; requests present during flush are not consumed.
- Requester protocol:
  - The gnt bit marks consumption.
  - Deassert req the next cycle, or keep it asserted for a new operation with new operands.
- Simultaneous flush and res_ready=1 with res_valid=1: flush wins; the result counts as dropped, not delivered.
- Operand values of non-granted requesters are ignored; pass_b of non-granted requesters is ignored.

Optional Feature:
- Macro: ADDER_ARB_PERF_EN.
- Defined:
  - Adds output conflict_cnt [15:0].
  - Increments on each clk edge where (req & ~gnt)!=0, i.e. some requester was denied (contention, stall or flush).
  - Saturates at 0xFFFF; cleared to 0 by rst_n.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- lui: req=001, pass_b=001, op_b[0]=0x12345000.
  - Same cycle: gnt=001.
  - Next edge: res_valid=1, result=0x12345000, res_tag=0.
- auipc plus wrap:
  - req=001, pass_b=0, op_a[0]=0x00000100, op_b[0]=0x00001000 -> result=0x00001100.
  - Then op_a=0xFFFFFFFF, op_b=0x00000001 -> result=0x00000000.
- Contention: req=111 held 4 cycles from reset, res_ready=1 -> gnt sequence 001, 010, 100, 001; res_tag sequence 0, 1, 2, 0 one cycle later.
- Backpressure: res_valid=1 with result=0x00002000, res_ready=0 for 3 cycles, req=010 pending.
  - gnt=000 and result/res_tag stable throughout.
  - res_ready=1 -> gnt=010 that cycle.
- Flush: req=100 with flush=1.
  - gnt=000; next cycle res_valid=0; rr_ptr unchanged.
  - Following cycle without flush: gnt=100.
- Reset mid-stream: rst_n low between edges while res_valid=1.
  - Immediately res_valid=0, result=0.
  - After release: req=110 -> gnt=010 (pointer back to 0).
  - With ADDER_ARB_PERF_EN: conflict_cnt=0 after reset, =1 after that cycle.
